// File: rtl/spm_ctrl_pkg.sv
// Shared types for the serial/parallel multiplier sequencer.
package spm_ctrl_pkg;

  localparam int SPM_N = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CLR  = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/spm_ctrl.sv
// Sequencer for the serial/parallel multiplier: loads operands, streams y LSB-first,
// deserialises the product bit-stream and hands the 2N-bit product to a consumer.
module spm_ctrl
  import spm_ctrl_pkg::*;
#(
  parameter int N     = SPM_N,
  parameter int P_LAT = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [N-1:0]     op_x,
  input  logic [N-1:0]     op_y,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [2*N-1:0]   res_p,
  output logic             busy,
  output logic             spm_rst,
  output logic [N-1:0]     spm_x,
  output logic             spm_y,
  input  logic             spm_p
);

  localparam int RUN_LEN = 2 * N + P_LAT;
  localparam int CW      = $clog2(RUN_LEN + 1);

  state_t          state;
  logic [N-1:0]    yreg;
  logic [2*N-1:0]  preg;
  logic [2*N-1:0]  preg_nxt;
  logic [CW-1:0]   cnt;
  logic            last;
  logic            cap;

  assign preg_nxt = {spm_p, preg[2*N-1:1]};
  assign last     = (cnt == CW'(RUN_LEN - 1));

  // Product bits only become meaningful once the spm pipeline has filled.
  generate
    if (P_LAT == 0) begin : g_cap_always
      assign cap = 1'b1;
    end else begin : g_cap_delayed
      assign cap = (cnt >= CW'(P_LAT));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      op_ready  <= 1'b1;
      res_valid <= 1'b0;
      res_p     <= '0;
      busy      <= 1'b0;
      spm_rst   <= 1'b1;
      spm_x     <= '0;
      spm_y     <= 1'b0;
      yreg      <= '0;
      preg      <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (op_valid) begin
            spm_x    <= op_x;
            yreg     <= op_y;
            cnt      <= '0;
            preg     <= '0;
            op_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= CLR;
          end
        end
        CLR: begin
          spm_rst <= 1'b0;
          spm_y   <= yreg[0];
          yreg    <= {1'b0, yreg[N-1:1]};
          state   <= RUN;
        end
        RUN: begin
          cnt <= cnt + 1'b1;
          if (cap) begin
            preg <= preg_nxt;
          end
          if (last) begin
            res_p     <= preg_nxt;
            res_valid <= 1'b1;
            spm_rst   <= 1'b1;
            spm_y     <= 1'b0;
            state     <= DONE;
          end else begin
            // Once y is exhausted the zero fill lets the upper product bits drain out.
            spm_y <= yreg[0];
            yreg  <= {1'b0, yreg[N-1:1]};
          end
        end
        DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            op_ready  <= 1'b1;
            busy      <= 1'b0;
            spm_x     <= '0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spm_ctrl.sv
// Bench for spm_ctrl with a behavioural serial/parallel multiplier beside it.
module tb_spm_ctrl;

  localparam int N = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           op_valid = 1'b0;
  logic           op_ready;
  logic [N-1:0]   op_x = '0;
  logic [N-1:0]   op_y = '0;
  logic           res_valid;
  logic           res_ready;
  logic [2*N-1:0] res_p;
  logic           busy;
  logic           spm_rst;
  logic [N-1:0]   spm_x;
  logic           spm_y;
  logic           spm_p;

  logic rdy_force = 1'b0;
  logic rnd_en    = 1'b0;
  logic rnd_bit   = 1'b0;
  assign res_ready = rdy_force | (rnd_en & rnd_bit);

  int n_vec  = 0;
  int n_fail = 0;
  logic [15:0] expq[$];

  spm_ctrl #(.N(N), .P_LAT(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .op_valid(op_valid), .op_ready(op_ready), .op_x(op_x), .op_y(op_y),
    .res_valid(res_valid), .res_ready(res_ready), .res_p(res_p),
    .busy(busy), .spm_rst(spm_rst), .spm_x(spm_x), .spm_y(spm_y), .spm_p(spm_p)
  );

  // Serial/parallel multiplier model: one product bit per cycle, LSB first.
  logic [N:0] acc;
  logic [N:0] sum;
  always_comb sum = acc + (spm_y ? {1'b0, spm_x} : '0);
  assign spm_p = sum[0];
  always @(posedge clk) begin
    if (spm_rst) acc <= '0;
    else         acc <= sum >> 1;
  end

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    #1;
    rnd_bit = 1'($urandom_range(0, 1));
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Monitor: every product handshake must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && res_valid && res_ready) begin
      if (expq.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL unexpected_result: got %0h, none outstanding", res_p);
      end else begin
        check("res_p", 32'(res_p), 32'(expq.pop_front()));
      end
    end
  end

  task automatic send(input logic [7:0] x, input logic [7:0] y, input logic [15:0] e,
                      input bit push);
    int t = 0;
    op_valid = 1'b1;
    op_x = x;
    op_y = y;
    @(negedge clk);
    while (!op_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!op_ready) begin
      check("accept_timeout", 32'(op_ready), 32'd1);
    end else if (push) begin
      expq.push_back(e);
    end
    @(posedge clk);
    #1;
    op_valid = 1'b0;
  endtask

  task automatic wait_valid();
    int t = 0;
    while (!res_valid && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (!res_valid) check("valid_timeout", 32'(res_valid), 32'd1);
  endtask

  initial begin
    int cycles;
    int t;
    logic seen;
    logic [7:0] rx, ry;
    logic [15:0] re;

    // Power-on reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_op_ready", 32'(op_ready), 32'd1);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_spm_rst", 32'(spm_rst), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_res_p", 32'(res_p), 32'd0);
    check("rst_spm_x", 32'(spm_x), 32'd0);
    check("rst_spm_y", 32'(spm_y), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 50 * 206 with latency measured from the accept cycle
    rdy_force = 1'b1;
    send(8'd50, 8'd206, 16'h283C, 1'b1);
    cycles = 1;
    while (!res_valid && cycles < 60) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    check("latency", 32'(cycles), 32'd18);
    check("res_p_283c", 32'(res_p), 32'h283C);
    @(posedge clk);
    #1;
    check("idle_op_ready", 32'(op_ready), 32'd1);
    check("idle_res_valid", 32'(res_valid), 32'd0);

    // Asynchronous reset mid-clock during RUN
    send(8'd9, 8'd9, 16'd81, 1'b0);
    repeat (4) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_op_ready", 32'(op_ready), 32'd1);
    check("arst_res_valid", 32'(res_valid), 32'd0);
    check("arst_spm_rst", 32'(spm_rst), 32'd1);
    check("arst_res_p", 32'(res_p), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Consumer stall: product held stable until accepted
    rdy_force = 1'b0;
    send(8'd127, 8'd255, 16'h7E81, 1'b1);
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", 32'(res_valid), 32'd1);
      check("stall_res_p", 32'(res_p), 32'h7E81);
      @(posedge clk);
      #1;
    end
    rdy_force = 1'b1;
    @(posedge clk);
    #1;
    check("release_valid", 32'(res_valid), 32'd0);
    check("release_op_ready", 32'(op_ready), 32'd1);

    // op_valid held high with changing operands while busy
    rdy_force = 1'b0;
    send(8'd10, 8'd20, 16'd200, 1'b1);
    op_valid = 1'b1;
    for (int i = 0; i < 22; i++) begin
      op_x = 8'($urandom);
      op_y = 8'($urandom);
      @(negedge clk);
      check("busy_op_ready", 32'(op_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    check("held_res_p", 32'(res_p), 32'd200);
    op_x = 8'd7;
    op_y = 8'd9;
    rdy_force = 1'b1;
    t = 0;
    @(negedge clk);
    while (!op_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("accept_after_done", 32'(t), 32'd1);
    check("accept_res_valid", 32'(res_valid), 32'd0);
    expq.push_back(16'd63);
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    wait_valid();
    @(posedge clk);
    #1;

    // Reset pulse during RUN cycle 7 discards the operation
    send(8'd100, 8'd100, 16'd10000, 1'b0);
    repeat (8) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_op_ready", 32'(op_ready), 32'd1);
    check("abort_spm_rst", 32'(spm_rst), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      @(posedge clk);
      #1;
      seen |= res_valid;
    end
    check("abort_no_result", 32'(seen), 32'd0);
    send(8'd3, 8'd5, 16'h000F, 1'b1);
    wait_valid();
    check("after_abort_res_p", 32'(res_p), 32'h000F);
    @(posedge clk);
    #1;

    // Back-to-back operations with a randomly stalling consumer
    rdy_force = 1'b0;
    rnd_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      rx = 8'($urandom_range(0, 127));
      ry = 8'($urandom_range(0, 255));
      re = 16'(rx) * 16'(ry);
      send(rx, ry, re, 1'b1);
    end
    t = 0;
    while (expq.size() != 0 && t < 3000) begin
      @(posedge clk);
      t++;
    end
    check("drain", 32'(expq.size()), 32'd0);
    repeat (3) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
